imm_gen_pipe: RTL

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

---
 rtl/imm_gen_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
// Immediate generator for RV32/RV64 instruction formats feeding a DEPTH-entry output FIFO.
// Optional build macro IMM_GEN_ILLEGAL_CNT_EN adds a saturating illegal-format counter.
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [24:0]     instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic            imm_illegal,
    output logic [3:0]      fill,
    output logic [15:0]     illegal_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic            illegal;
        logic [XLEN-1:0] imm;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic [3:0]       fill_nxt;
    logic             push;
    logic             pop;
    logic             bypass;
    logic [31:0]      imm32;
    logic             illegal;
    entry_t           new_entry;
    entry_t           head_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // instr[k] is instruction bit k+7, so instruction bit n maps to instr[n-7]
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (imm_src)
            3'b000:  imm32 = {{20{instr[24]}}, instr[24:13]};
            3'b001:  imm32 = {{20{instr[24]}}, instr[24:18], instr[4:0]};
            3'b010:  imm32 = {{19{instr[24]}}, instr[24], instr[0], instr[23:18], instr[4:1], 1'b0};
            3'b011:  imm32 = {{11{instr[24]}}, instr[24], instr[12:5], instr[13], instr[23:14], 1'b0};
            3'b100:  imm32 = {instr[24:5], 12'b0};
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        new_entry.illegal = illegal;
        new_entry.imm     = XLEN'($signed(imm32));
    end

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        fill_nxt = fill;
        if (push && !pop)      fill_nxt = fill + 4'd1;
        else if (pop && !push) fill_nxt = fill - 4'd1;
    end

    assign rd_nxt = pop ? ptr_inc(rd_ptr) : rd_ptr;

    // New entry lands directly at the head when nothing older remains after the pop
    assign bypass   = push && (fill == (pop ? 4'd1 : 4'd0));
    assign head_nxt = bypass ? new_entry : mem[rd_nxt];

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= new_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fill        <= '0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
            imm_ext     <= '0;
            imm_illegal <= 1'b0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            rd_ptr    <= rd_nxt;
            fill      <= fill_nxt;
            out_valid <= (fill_nxt != 4'd0);
            in_ready  <= (fill_nxt < 4'(DEPTH));
            // Empty buffer keeps the last dequeued head visible
            if (fill_nxt != 4'd0) {imm_illegal, imm_ext} <= head_nxt;
        end
    end

`ifdef IMM_GEN_ILLEGAL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_cnt <= '0;
        end else if (push && illegal && (illegal_cnt != 16'hFFFF)) begin
            illegal_cnt <= illegal_cnt + 16'd1;
        end
    end
`else
    assign illegal_cnt = '0;
`endif

endmodule
